// File: rtl/switch_debouncer.sv
// Synchroniser plus per-channel stability counter for raw slide switches.
// Optional rise/fall pulse outputs are built only when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debouncer #(
  parameter int          N_CH            = 2,
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd10_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  // state   | meaning
  // STABLE  | s2 == sw_out, cnt held at 0
  // PENDING | s2 != sw_out, cnt counting toward term_cnt
  localparam logic [23:0] TERM_CNT = DEBOUNCE_CYCLES - 24'd1;

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [23:0]     cnt     [N_CH];
  logic [23:0]     cnt_nxt [N_CH];
  logic [N_CH-1:0] commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  // Any return to the stable level drops the partial count.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
      commit[i]  = 1'b0;
      if (ena && (s2[i] != sw_out[i])) begin
        if (cnt[i] == TERM_CNT) begin
          commit[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 24'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
      sw_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      sw_out <= (sw_out & ~commit) | (s2 & commit);
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= commit & s2;
      fall <= commit & ~s2;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
